// File: rtl/uart_tx_cfg.sv
// Register-mapped UART transmitter with runtime frame format (5-8 data bits,
// optional even/odd parity, 1 or 2 stop bits) fed from a TX FIFO.
module uart_tx_cfg #(
  parameter int          FIFO_DEPTH = 16,
  parameter int          FIFO_AW    = 4,
  parameter logic [7:0]  PERIOD_RST = 8'h0C,
  parameter logic [7:0]  CTRL_RST   = 8'h23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wren,
  input  logic       rden,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       txout
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;
  localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  state_t state, state_n;

  logic [7:0]         period_q;
  logic [5:0]         ctrl_q;
  logic               txdone_q, ovf_q;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count;

  logic [8:0]         baud_cnt;
  logic [4:0]         tick_cnt;
  logic [7:0]         shreg;
  logic [2:0]         bit_cnt;
  logic [1:0]         len_q;
  logic               par_en_q, par_bit_q, stop2_q;

  logic               full, empty, busy, tick, bit_end, load, push;
  logic               txdone_set, txdone_clr, ovf_set, ovf_clr, tx_c;
  logic [7:0]         head, mask, level8, rdata, status;
  logic [8:0]         count9;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign busy    = (state != IDLE);
  assign head    = mem[rptr];
  assign mask    = 8'hFF >> (2'd3 - ctrl_q[1:0]);
  assign tick    = busy && (baud_cnt == 9'd0);
  assign bit_end = tick && (tick_cnt == ((state == STOP && stop2_q) ? 5'd31 : 5'd15));

  // A new frame may begin from IDLE or directly at the end of a stop bit.
  assign load = ctrl_q[5] && !empty && (state == IDLE || (state == STOP && bit_end));
  assign push = wren && (addr == 3'd1) && !full;

  assign txdone_set = (state == STOP) && bit_end;
  assign txdone_clr = wren && (addr == 3'd3) && !din[1];
  assign ovf_set    = wren && (addr == 3'd1) && full;
  assign ovf_clr    = wren && (addr == 3'd3) && !din[2];

  assign count9 = 9'(count);
  assign level8 = count9[8] ? 8'hFF : count9[7:0];
  assign status = {3'b000, busy, empty, ovf_q, txdone_q, full};

  always_comb begin
    rdata = 8'h00;
    case (addr)
      3'd0:    rdata = period_q;
      3'd2:    rdata = {2'b00, ctrl_q};
      3'd3:    rdata = status;
      3'd4:    rdata = level8;
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    tx_c    = 1'b1;
    case (state)
      IDLE:   if (load) state_n = START;
      START: begin
        tx_c = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx_c = shreg[0];
        if (bit_end && bit_cnt == (3'd4 + {1'b0, len_q}))
          state_n = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_c = par_bit_q;
        if (bit_end) state_n = STOP;
      end
      STOP:   if (bit_end) state_n = load ? START : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Baud counter reloads from PERIOD only at terminal count or frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt  <= '0;
      tick_cnt  <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      len_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      txout     <= 1'b1;
    end else begin
      txout <= tx_c;
      if (load) begin
        baud_cnt  <= {period_q, 1'b1};
        tick_cnt  <= '0;
        shreg     <= head;
        bit_cnt   <= '0;
        len_q     <= ctrl_q[1:0];
        par_en_q  <= ctrl_q[3] ^ ctrl_q[2];
        par_bit_q <= (^(head & mask)) ^ (ctrl_q[3] & ~ctrl_q[2]);
        stop2_q   <= ctrl_q[4];
      end else if (busy) begin
        if (tick) begin
          baud_cnt <= {period_q, 1'b1};
          tick_cnt <= bit_end ? 5'd0 : tick_cnt + 5'd1;
        end else begin
          baud_cnt <= baud_cnt - 9'd1;
        end
        if (bit_end && state == DATA) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= PERIOD_RST;
      ctrl_q   <= CTRL_RST[5:0];
      txdone_q <= 1'b0;
      ovf_q    <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      dout     <= 8'h00;
    end else begin
      if (wren && addr == 3'd0) period_q <= din;
      if (wren && addr == 3'd2) ctrl_q   <= din[5:0];
      txdone_q <= txdone_set | (txdone_q & ~txdone_clr);
      ovf_q    <= ovf_set | (ovf_q & ~ovf_clr);
      if (push) wptr <= wptr + PTR_ONE;
      if (load) rptr <= rptr + PTR_ONE;
      case ({push, load})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      dout <= rden ? rdata : 8'h00;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed and randomized bench for uart_tx_cfg: a line receiver samples each
// bit mid-period and compares against a frame model built from the format rules.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wren = 1'b0;
  logic       rden = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       txout;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  uart_tx_cfg dut (
    .clk(clk), .reset(reset), .wren(wren), .rden(rden),
    .addr(addr), .din(din), .dout(dout), .txout(txout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wren = 1'b1; addr = a; din = d;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    rden = 1'b1; addr = a;
    @(posedge clk);
    #1 d = dout;
    @(negedge clk);
    rden = 1'b0;
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Expected line bits (index 0 = start), unused upper bits left at idle 1.
  function automatic logic [15:0] modelFrame(input logic [7:0] d, input logic [7:0] c, output int len);
    logic [15:0] f;
    int n, ones, pos;
    f = '1; f[0] = 1'b0; ones = 0;
    n = 5 + int'(c[1:0]);
    for (int i = 0; i < n; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    pos = 1 + n;
    if (c[3:2] == 2'b01) begin f[pos] = 1'((ones % 2)); pos++; end
    else if (c[3:2] == 2'b10) begin f[pos] = 1'((ones + 1) % 2); pos++; end
    pos += c[4] ? 2 : 1;
    len = pos;
    return f;
  endfunction

  task automatic receiveFrame(input int bclk, input int nbits, output logic [15:0] bits,
                              output int fall, output int lowlen);
    int n;
    logic to;
    bits = '1; n = 0; lowlen = 0;
    @(negedge clk);
    while (txout !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    to = (txout !== 1'b0);
    checkOutput("rx_start_seen", 16'(to), 16'd0);
    fall = cyc;
    if (!to) begin
      while (txout === 1'b0 && (cyc - fall) < bclk + 8) @(negedge clk);
      lowlen = cyc - fall;
      bits[0] = (lowlen >= bclk / 2) ? 1'b0 : 1'b1;
      for (int k = 1; k < nbits; k++) begin
        waitCyc(fall + k * bclk + bclk / 2);
        bits[k] = txout;
      end
    end
  endtask

  task automatic checkDoneTiming(input int fall, input int flen, input int bclk);
    logic [7:0] s;
    waitCyc(fall + flen * bclk - 20);
    readReg(3'd3, s);
    checkOutput("status_busy_before_end", 16'(s), 16'h0018);
    waitCyc(fall + flen * bclk + 10);
    readReg(3'd3, s);
    checkOutput("status_done_after_end", 16'(s), 16'h000A);
  endtask

  initial begin
    logic [7:0]  r;
    logic [15:0] obs, exp;
    int          fall, prev, lowlen, flen, b, low_seen;
    logic [7:0]  c, d;

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values
    readReg(3'd0, r); checkOutput("rst_period", 16'(r), 16'h000C);
    readReg(3'd2, r); checkOutput("rst_ctrl",   16'(r), 16'h0023);
    readReg(3'd3, r); checkOutput("rst_status", 16'(r), 16'h0008);
    readReg(3'd4, r); checkOutput("rst_level",  16'(r), 16'h0000);
    readReg(3'd5, r); checkOutput("rd_addr5",   16'(r), 16'h0000);
    @(negedge clk);   checkOutput("dout_idle_zero", 16'(dout), 16'h0000);
    checkOutput("rst_txout", 16'(txout), 16'h0001);

    // 8N1 0x55 at 416 clocks per bit
    applyStimulus(3'd1, 8'h55);
    receiveFrame(416, 10, obs, fall, lowlen);
    exp = modelFrame(8'h55, 8'h23, flen);
    checkOutput("frame_55", obs, exp);
    checkOutput("start_len_416", 16'(lowlen), 16'd416);
    checkDoneTiming(fall, 10, 416);
    applyStimulus(3'd3, 8'h00);
    readReg(3'd3, r); checkOutput("txdone_cleared", 16'(r), 16'h0008);

    // 7E2 back-to-back, then 7O2
    applyStimulus(3'd2, 8'h16);
    applyStimulus(3'd1, 8'h41);
    applyStimulus(3'd1, 8'h41);
    readReg(3'd1, r); checkOutput("txdata_reads_zero", 16'(r), 16'h0000);
    applyStimulus(3'd2, 8'h36);
    for (int i = 0; i < 2; i++) begin
      prev = fall;
      receiveFrame(416, 11, obs, fall, lowlen);
      exp = modelFrame(8'h41, 8'h36, flen);
      checkOutput("frame_7E2", obs, exp);
      if (i == 1) checkOutput("gap_7E2", 16'(fall - prev), 16'd4576);
    end
    applyStimulus(3'd2, 8'h3A);
    applyStimulus(3'd1, 8'h41);
    receiveFrame(416, 11, obs, fall, lowlen);
    exp = modelFrame(8'h41, 8'h3A, flen);
    checkOutput("frame_7O2", obs, exp);

    // FIFO fill with transmitter disabled, overflow, then drain
    waitCyc(fall + 11 * 416 + 4);
    applyStimulus(3'd0, 8'h00);
    applyStimulus(3'd2, 8'h03);
    applyStimulus(3'd3, 8'h00);
    for (int i = 0; i < 16; i++) applyStimulus(3'd1, 8'h30 + 8'(i));
    readReg(3'd4, r); checkOutput("level_full", 16'(r), 16'h0010);
    readReg(3'd3, r); checkOutput("status_full", 16'(r), 16'h0001);
    checkOutput("txout_idle_disabled", 16'(txout), 16'h0001);
    applyStimulus(3'd1, 8'h99);
    readReg(3'd3, r); checkOutput("status_ovf", 16'(r), 16'h0005);
    readReg(3'd4, r); checkOutput("level_after_ovf", 16'(r), 16'h0010);
    applyStimulus(3'd2, 8'h23);
    for (int i = 0; i < 16; i++) begin
      prev = fall;
      receiveFrame(32, 10, obs, fall, lowlen);
      exp = modelFrame(8'h30 + 8'(i), 8'h23, flen);
      checkOutput($sformatf("fifo_frame_%0d", i), obs, exp);
      if (i > 0) checkOutput("fifo_gap", 16'(fall - prev), 16'd320);
    end
    waitCyc(fall + 320 + 40);
    readReg(3'd3, r); checkOutput("status_drained", 16'(r), 16'h000E);

    // 5N1 0xFF
    applyStimulus(3'd0, 8'h0C);
    applyStimulus(3'd3, 8'h00);
    applyStimulus(3'd2, 8'h20);
    applyStimulus(3'd1, 8'hFF);
    receiveFrame(416, 7, obs, fall, lowlen);
    exp = modelFrame(8'hFF, 8'h20, flen);
    checkOutput("frame_5N1", obs, exp);
    checkOutput("start_len_5N1", 16'(lowlen), 16'd416);
    checkDoneTiming(fall, 7, 416);

    // Reset mid-frame with bytes queued
    applyStimulus(3'd0, 8'h00);
    applyStimulus(3'd2, 8'h03);
    for (int i = 0; i < 3; i++) applyStimulus(3'd1, 8'hA0 + 8'(i));
    applyStimulus(3'd2, 8'h23);
    receiveFrame(32, 3, obs, fall, lowlen);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("txout_after_reset", 16'(txout), 16'h0001);
    @(negedge clk); reset = 1'b0;
    readReg(3'd4, r); checkOutput("level_after_reset", 16'(r), 16'h0000);
    readReg(3'd0, r); checkOutput("period_after_reset", 16'(r), 16'h000C);
    low_seen = 0;
    repeat (12000) begin
      @(negedge clk);
      if (txout !== 1'b1) low_seen++;
    end
    checkOutput("quiet_after_reset", 16'(low_seen), 16'd0);

    // Randomized formats, data and baud
    for (int i = 0; i < 8; i++) begin
      b = 32 * (int'($urandom_range(0, 2)) + 1);
      c = {3'b001, 5'($urandom)};
      d = 8'($urandom);
      applyStimulus(3'd0, 8'(b / 32 - 1));
      applyStimulus(3'd2, c);
      exp = modelFrame(d, c, flen);
      applyStimulus(3'd1, d);
      receiveFrame(b, flen, obs, fall, lowlen);
      checkOutput($sformatf("rand_frame_c%02h_d%02h", c, d), obs, exp);
      waitCyc(fall + flen * b + 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
